// File: rtl/home_event_scheduler.sv
// -----------------------------------------------------------------------------
// home_event_scheduler
//
// Round-robin arbiter that shares the single-active actuator/display path of
// the home automation controller among six sensor-derived requesters
// (front door, rear door, fire alarm, window, heat, cool). Sensor events are
// latched as pending. Exactly one actuator is granted at a time for
// HOLD_CYCLES cycles. Each grant is followed by a one-cycle all-off gap.
//
// All state changes happen on the FALLING edge of Clk. Rst is synchronous and
// active-high.
//
// Optional feature (compile-time macro FIRE_PREEMPT_EN):
//   When defined, an asserted SFA during another requester's grant switches
//   the grant straight to the fire alarm. There is no gap. The aborted
//   requester is re-pended. When undefined, SFA is an ordinary requester.
//
// Parameters:
//   HOLD_CYCLES  cycles an actuator stays on per grant (>= 1)
//   T_LOW        heat request when ST < T_LOW
//   T_HIGH       cool request when ST > T_HIGH
//
// Ports:
//   Clk                  clock (falling-edge active)
//   Rst                  synchronous active-high reset
//   SFD, SRD, SFA, SW    door / alarm / window sensor levels
//   ST[6:0]              unsigned temperature
//   clr                  clears all pending bits (current grant unaffected)
//   fdoor .. cooler      actuators, at most one high
//   display[2:0]         granted code: 1 FD,2 RD,3 FA,4 W,5 heat,6 cool,0 none
//   pending[5:0]         latched requests (bit0 FD .. bit5 cool)
//   busy                 high while a grant is active
// -----------------------------------------------------------------------------
module home_event_scheduler #(
    parameter int HOLD_CYCLES = 8,
    parameter int T_LOW       = 50,
    parameter int T_HIGH      = 70
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SFD,
    input  logic       SRD,
    input  logic       SFA,
    input  logic       SW,
    input  logic [6:0] ST,
    input  logic       clr,
    output logic       fdoor,
    output logic       rdoor,
    output logic       alarmbuzz,
    output logic       winbuzz,
    output logic       heater,
    output logic       cooler,
    output logic [2:0] display,
    output logic [5:0] pending,
    output logic       busy
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    localparam logic [6:0] T_LOW_C  = 7'(T_LOW);
    localparam logic [6:0] T_HIGH_C = 7'(T_HIGH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [2:0] FA_IDX = 3'd2;

    // One-hot vector for requester index i (0..5).
    function automatic logic [5:0] onehot6(input logic [2:0] i);
        return 6'b000001 << i;
    endfunction

    // The first set bit of c, searching from p upward and wrapping 5 -> 0.
    function automatic logic [2:0] rr_pick(input logic [5:0] c, input logic [2:0] p);
        logic [2:0] pick;
        logic [2:0] k3;
        logic       found;
        int         k;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            k = int'(p) + i;
            if (k >= 6) begin
                k = k - 6;
            end else begin
                k = k;
            end
            k3 = 3'(k);
            if (!found && c[k3]) begin
                pick  = k3;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    logic [1:0]    state_r, state_n;
    logic [2:0]    ptr_r, ptr_n;
    logic [2:0]    g_r, g_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [5:0]    pending_r, pending_n;
    logic [5:0]    act_r, act_n;
    logic [2:0]    disp_r, disp_n;
    logic          busy_r, busy_n;

    logic [5:0]    req_s;
    logic [5:0]    cand_s;
    logic [2:0]    pick_s;
    logic          preempt_s;

    assign req_s  = {(ST > T_HIGH_C), (ST < T_LOW_C), SW, SFA, SRD, SFD};
    // Same-edge requests take part in arbitration together with latched ones.
    assign cand_s = pending_r | req_s;
    assign pick_s = rr_pick(cand_s, ptr_r);

`ifdef FIRE_PREEMPT_EN
    assign preempt_s = (state_r == ST_GRANT) && SFA && (g_r != FA_IDX);
`else
    assign preempt_s = 1'b0;
`endif

    // Next-state, grant and pending computation.
    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        g_n       = g_r;
        cnt_n     = cnt_r;
        act_n     = act_r;
        disp_n    = disp_r;
        busy_n    = busy_r;
        pending_n = pending_r | req_s;

        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (cand_s != 6'd0) begin
                    state_n   = ST_GRANT;
                    g_n       = pick_s;
                    cnt_n     = CNT_LOAD;
                    act_n     = onehot6(pick_s);
                    disp_n    = pick_s + 3'd1;
                    busy_n    = 1'b1;
                    // The granted bit is consumed, even if its sensor is still high now.
                    pending_n = (pending_r | req_s) & ~onehot6(pick_s);
                end else begin
                    state_n = ST_IDLE;
                    act_n   = 6'd0;
                    disp_n  = 3'd0;
                    busy_n  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (preempt_s) begin
                    // Switch straight to the alarm. ptr stays put, so it
                    // becomes 3 when the alarm grant completes.
                    g_n       = FA_IDX;
                    cnt_n     = CNT_LOAD;
                    act_n     = onehot6(FA_IDX);
                    disp_n    = 3'd3;
                    pending_n = (pending_r | req_s | onehot6(g_r)) & ~onehot6(FA_IDX);
                end else if (cnt_r == CNT_ZERO) begin
                    state_n = ST_GAP;
                    act_n   = 6'd0;
                    disp_n  = 3'd0;
                    busy_n  = 1'b0;
                    ptr_n   = (g_r == 3'd5) ? 3'd0 : (g_r + 3'd1);
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                act_n   = 6'd0;
                disp_n  = 3'd0;
                busy_n  = 1'b0;
            end
        endcase

        // clr overrides everything that would set a pending bit on this edge.
        if (clr) begin
            pending_n = 6'd0;
        end else begin
            pending_n = pending_n;
        end
    end

    // State and output registers, updated on the falling edge.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 3'd0;
            g_r       <= 3'd0;
            cnt_r     <= CNT_ZERO;
            pending_r <= 6'd0;
            act_r     <= 6'd0;
            disp_r    <= 3'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            ptr_r     <= ptr_n;
            g_r       <= g_n;
            cnt_r     <= cnt_n;
            pending_r <= pending_n;
            act_r     <= act_n;
            disp_r    <= disp_n;
            busy_r    <= busy_n;
        end
    end

    assign fdoor     = act_r[0];
    assign rdoor     = act_r[1];
    assign alarmbuzz = act_r[2];
    assign winbuzz   = act_r[3];
    assign heater    = act_r[4];
    assign cooler    = act_r[5];
    assign display   = disp_r;
    assign pending   = pending_r;
    assign busy      = busy_r;

endmodule

// File: doc/home_event_scheduler.md
# home_event_scheduler

Round-robin scheduler that shares the single-active actuator/display path of the home automation controller among six sensor-derived requesters: front door, rear door, fire alarm, window, heat, cool. Sensor events are latched as pending, and exactly one actuator is granted at a time for a fixed hold window, with a one-cycle all-off gap between grants. It sits between the raw sensor inputs and the actuator/display outputs. It provides fairness that a fixed-priority chain cannot.

## Interface
- HOLD_CYCLES, 8, cycles an actuator stays on per grant (>= 1)
- T_LOW, 50, heat request when ST < T_LOW
- T_HIGH, 70, cool request when ST > T_HIGH
- Clk  in  1  clock; all state updates on the falling edge of Clk
- Rst  in  1  reset; synchronous, active-high
- SFD, SRD, SFA, SW  in  1 each  front door, rear door, fire alarm, window sensors (level)
- ST  in  7  temperature, unsigned
- clr  in  1  clears all pending bits (current grant unaffected)
- fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler  out  1 each  actuators; at most one high
- display  out  3  code of granted requester: 1 FD, 2 RD, 3 FA, 4 W, 5 heat, 6 cool; 0 none
- pending  out  6  latched requests; bit0 FD, 1 RD, 2 FA, 3 W, 4 heat, 5 cool
- busy  out  1  high in GRANT

## Operation
- req[5:0] = {ST>T_HIGH, ST<T_LOW, SW, SFA, SRD, SFD}; compares unsigned 7-bit, so ST=50 gives no heat and ST=70 gives no cool.
- Every edge: pending <= pending | req, except as noted below.
- cand = pending | req. The same-edge request is visible to arbitration.
- Arbitration: the first set bit of cand searching ptr, ptr+1, …, wrapping 5→0.
- States:
  - IDLE: if cand≠0, grant g, go to GRANT; otherwise stay.
  - GRANT: hold counter counts down from HOLD_CYCLES-1. At 0, go to GAP, drive outputs and display to 0, set ptr <= (g==5) ? 0 : g+1.
  - GAP: outputs off. If cand≠0, arbitrate and go to GRANT; otherwise go to IDLE.
- On a grant edge:
  - Actuator g goes high and display is set to its code.
  - pending[g] is cleared; req[g] at that edge is ignored for bit g.
  - Other bits OR in req.
- A sensor still asserted during its own grant re-pends and is served again in its round-robin turn.
- clr: pending <= 0 at that edge. clr beats req for that edge.
- Reset: state IDLE, ptr 0, counter 0, pending 0, all actuators 0, display 0, busy 0. This applies mid-grant too; the outputs drop at the reset edge.

## Timing
- Request sampled at edge N while IDLE: actuator high after edge N (0-cycle latency).
- Grant duration is exactly HOLD_CYCLES cycles, followed by a 1-cycle gap.
- Back-to-back grant period is HOLD_CYCLES+1.
- HOLD_CYCLES=1: GRANT lasts one cycle.
- Counter width is $clog2(HOLD_CYCLES+1).
- Outputs are registered and change only on falling edges.
- The one-hot invariant holds in every cycle, including the preempt edge.

## Configuration
- FIRE_PREEMPT_EN defined:
  - Trigger: in GRANT with g≠FA and SFA=1 at an edge.
  - Action at that edge: switch directly to grant FA, with no gap. alarmbuzz goes high, display becomes 3, and the counter reloads to HOLD_CYCLES-1.
  - The aborted requester's pending bit is set to 1.
  - ptr is unchanged until the FA grant completes; it then becomes 3.
- FIRE_PREEMPT_EN undefined: SFA is an ordinary requester and waits its round-robin turn.

## Test plan
- Rst high for 2 edges with sensors active -> all actuators 0, display 0, pending 0, busy 0. After release, the first grant is fdoor (ptr 0).
- HOLD_CYCLES=4, one-cycle SFD pulse in IDLE -> fdoor=1 and display=1 for 4 cycles, then 1 gap cycle at 0, then IDLE; pending ends at 0.
- SFD, SRD, SW pulsed together -> fdoor, rdoor, winbuzz granted in that order, each for 4 cycles, with a 1-cycle gap between; display 1, 2, 4.
- SFD and SRD held high continuously -> grants alternate 1,2,1,2; neither starves.
- ST=50 -> no heat request; ST=49 -> heater, display 5; ST=70 -> none; ST=71 -> cooler, display 6. clr during a pending heat with ST=60 -> pending[4]=0 and no heat grant.
- With FIRE_PREEMPT_EN, SW granted and SFA pulsed on the 2nd grant cycle -> alarmbuzz at the next edge (display 3) for 4 cycles, then gap, then winbuzz re-granted. Without the macro -> winbuzz completes 4 cycles, gap, then alarmbuzz.
